// File: rtl/rv32i_fde_core.sv
// Single-cycle RV32I fetch/decode/execute slice: PC, decode, ALU, branch/jump, halt on EBREAK.
// Optional FDE_MUL_EN adds MUL/MULH/MULHSU/MULHU; otherwise every funct7=0000001 OP is illegal.
module rv32i_fde_core #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] pc_o,
    input  logic [31:0]     inst_i,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            wen_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            halt_o,
    output logic            illegal_o
);
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;

    logic [XLEN-1:0] pc_q;
    logic            halted_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] pc_plus4, alu_b, alu_res, wdata_c, next_pc;
    logic [4:0]      shamt;
    logic            alu_ok, wr_c, ill_c, brk_c, take_c;

    assign opcode   = inst_i[6:0];
    assign funct3   = inst_i[14:12];
    assign funct7   = inst_i[31:25];
    assign rs1_o    = inst_i[19:15];
    assign rs2_o    = inst_i[24:20];
    assign rd_o     = inst_i[11:7];

    assign imm_i    = XLEN'($signed(inst_i[31:20]));
    assign imm_b    = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u    = XLEN'({inst_i[31:12], 12'b0});
    assign imm_j    = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign pc_plus4 = pc_q + XLEN'(4);

    // Shared ALU for OP and OP-IMM, plus funct7 legality
    always_comb begin
        alu_b   = (opcode == OPC_OP) ? src2_i : imm_i;
        shamt   = alu_b[4:0];
        alu_res = '0;
        alu_ok  = 1'b1;
        case (funct3)
            3'b000: alu_res = (opcode == OPC_OP && funct7 == F7_ALT) ? src1_i - alu_b
                                                                     : src1_i + alu_b;
            3'b001: alu_res = src1_i << shamt;
            3'b010: alu_res = XLEN'($signed(src1_i) < $signed(alu_b));
            3'b011: alu_res = XLEN'(src1_i < alu_b);
            3'b100: alu_res = src1_i ^ alu_b;
            3'b101: alu_res = (funct7 == F7_ALT) ? XLEN'($signed(src1_i) >>> shamt)
                                                 : src1_i >> shamt;
            3'b110: alu_res = src1_i | alu_b;
            3'b111: alu_res = src1_i & alu_b;
            default: alu_res = '0;
        endcase
        // funct7 qualifies every OP, but only the shifts in OP-IMM
        if (opcode == OPC_OP) begin
            alu_ok = (funct7 == F7_BASE) ||
                     (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (funct3 == 3'b001) begin
            alu_ok = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
            alu_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
    end

`ifdef FDE_MUL_EN
    localparam logic [6:0] F7_MUL = 7'b0000001;
    logic [63:0] mul_a, mul_b, mul_p;
    logic [31:0] mul_res;

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH; MUL low half is sign-agnostic
    always_comb begin
        mul_a   = {{32{(funct3[1:0] != 2'b11) & src1_i[31]}}, src1_i};
        mul_b   = {{32{(funct3[1:0] == 2'b01) & src2_i[31]}}, src2_i};
        mul_p   = mul_a * mul_b;
        mul_res = (funct3[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
    end
`endif

    always_comb begin
        wr_c    = 1'b0;
        ill_c   = 1'b0;
        brk_c   = 1'b0;
        take_c  = 1'b0;
        wdata_c = alu_res;
        next_pc = pc_plus4;
        case (opcode)
            OPC_OPIMM: begin
                wr_c  = 1'b1;
                ill_c = !alu_ok;
            end
            OPC_OP: begin
                wr_c  = 1'b1;
                ill_c = !alu_ok;
`ifdef FDE_MUL_EN
                if (funct7 == F7_MUL) begin
                    ill_c   = funct3[2];
                    wdata_c = mul_res;
                end
`endif
            end
            OPC_LUI: begin
                wr_c    = 1'b1;
                wdata_c = imm_u;
            end
            OPC_AUIPC: begin
                wr_c    = 1'b1;
                wdata_c = pc_q + imm_u;
            end
            OPC_JAL: begin
                wr_c    = 1'b1;
                wdata_c = pc_plus4;
                next_pc = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) begin
                    ill_c = 1'b1;
                end else begin
                    wr_c    = 1'b1;
                    wdata_c = pc_plus4;
                    next_pc = (src1_i + imm_i) & ~XLEN'(1);
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  take_c = (src1_i == src2_i);
                    3'b001:  take_c = (src1_i != src2_i);
                    3'b100:  take_c = ($signed(src1_i) <  $signed(src2_i));
                    3'b101:  take_c = ($signed(src1_i) >= $signed(src2_i));
                    3'b110:  take_c = (src1_i <  src2_i);
                    3'b111:  take_c = (src1_i >= src2_i);
                    default: ill_c  = 1'b1;
                endcase
                if (take_c) next_pc = pc_q + imm_b;
            end
            OPC_SYSTEM: begin
                if (inst_i == INST_EBREAK) brk_c = 1'b1;
                else                       ill_c = 1'b1;
            end
            default: ill_c = 1'b1;
        endcase
    end

    // PC and halt flag are the only architectural state here
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            halted_q <= brk_c;
            if (!brk_c) pc_q <= next_pc;
        end
    end

    assign pc_o      = pc_q;
    assign halt_o    = halted_q;
    assign illegal_o = ill_c;
    assign wdata_o   = wdata_c;
    assign wen_o     = wr_c & ~ill_c & (rd_o != 5'd0) & ~halted_q & ~rst_i;

endmodule

// File: tb/tb_rv32i_fde_core.sv
// Bench for rv32i_fde_core: instruction-level reference model checked every cycle,
// plus directed literal expectations. Honours FDE_MUL_EN the same way as the design.
module tb_rv32i_fde_core;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [6:0]  OP = 7'h33, OPI = 7'h13, LUI = 7'h37, AUIPC = 7'h17;
    localparam logic [6:0]  JAL = 7'h6f, JALR = 7'h67, BR = 7'h63;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_o, inst_i, src1_i, src2_i, wdata_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        wen_o, halt_o, illegal_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic        m_halt;
    logic        chk_en = 1'b0;

    typedef struct packed {
        logic        wen;
        logic [31:0] wdata;
        logic        ill;
        logic [31:0] npc;
        logic        nhalt;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    rv32i_fde_core dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_o(pc_o), .inst_i(inst_i),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .src1_i(src1_i), .src2_i(src2_i),
        .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o), .halt_o(halt_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    // Architectural reference: what one instruction does to rd and the PC
    function automatic exp_t model(input logic [31:0] ins, pc, a, b, input logic halted);
        exp_t        e;
        logic [6:0]  op  = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] ii  = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [31:0] iu  = {ins[31:12], 12'h000};
        logic [31:0] ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        logic [31:0] y   = 32'h0;
        logic [31:0] rhs;
        int          sa  = $signed(a);
        int          sr;
        longint      p;
        logic        wr  = 1'b0;
        logic        brk = 1'b0;
        logic        tk  = 1'b0;
        e.ill = 1'b0;
        e.npc = pc + 32'd4;
        if (op == OP || op == OPI) begin
            rhs = (op == OP) ? b : ii;
            sr  = $signed(rhs);
            wr  = 1'b1;
            case (f3)
                3'd0: y = (op == OP && f7 == 7'h20) ? a - rhs : a + rhs;
                3'd1: y = a << rhs[4:0];
                3'd2: y = (sa < sr) ? 32'd1 : 32'd0;
                3'd3: y = (a < rhs) ? 32'd1 : 32'd0;
                3'd4: y = a ^ rhs;
                3'd5: y = (f7 == 7'h20) ? 32'(sa >>> rhs[4:0]) : a >> rhs[4:0];
                3'd6: y = a | rhs;
                default: y = a & rhs;
            endcase
            if (op == OP)
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            else if (f3 == 3'd1)
                e.ill = (f7 != 7'h00);
            else if (f3 == 3'd5)
                e.ill = !(f7 == 7'h00 || f7 == 7'h20);
`ifdef FDE_MUL_EN
            if (op == OP && f7 == 7'h01) begin
                e.ill = f3[2];
                case (f3[1:0])
                    2'd0: p = longint'(sa) * longint'($signed(b));
                    2'd1: p = longint'(sa) * longint'($signed(b));
                    2'd2: p = longint'(sa) * longint'({32'h0, b});
                    default: p = longint'({32'h0, a}) * longint'({32'h0, b});
                endcase
                y = (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
            end
`endif
        end else if (op == LUI) begin
            wr = 1'b1; y = iu;
        end else if (op == AUIPC) begin
            wr = 1'b1; y = pc + iu;
        end else if (op == JAL) begin
            wr = 1'b1; y = pc + 32'd4; e.npc = pc + ij;
        end else if (op == JALR) begin
            if (f3 != 3'd0) e.ill = 1'b1;
            else begin
                wr = 1'b1; y = pc + 32'd4; e.npc = {32'(a + ii) >> 1, 1'b0};
            end
        end else if (op == BR) begin
            case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = (sa < $signed(b));
                3'd5: tk = (sa >= $signed(b));
                3'd6: tk = (a < b);
                3'd7: tk = (a >= b);
                default: e.ill = 1'b1;
            endcase
            if (tk) e.npc = pc + ib;
        end else if (ins == 32'h0010_0073) begin
            brk = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        e.wdata = y;
        e.wen   = wr && !e.ill && (ins[11:7] != 5'd0) && !halted;
        e.nhalt = halted || brk;
        if (halted || brk) e.npc = pc;
        return e;
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle on the falling edge
    always @(negedge clk_i) begin
        exp_t e;
        if (chk_en) begin
            e = model(inst_i, m_pc, src1_i, src2_i, m_halt);
            chk("pc",      pc_o,               m_pc);
            chk("halt",    32'(halt_o),        32'(m_halt));
            chk("illegal", 32'(illegal_o),     32'(e.ill));
            chk("wen",     32'(wen_o),         32'(e.wen));
            chk("rs1",     32'(rs1_o),         32'(inst_i[19:15]));
            chk("rs2",     32'(rs2_o),         32'(inst_i[24:20]));
            chk("rd",      32'(rd_o),          32'(inst_i[11:7]));
            if (e.wen) chk("wdata", wdata_o, e.wdata);
            m_pc   = e.npc;
            m_halt = e.nhalt;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        inst_i = ins;
        src1_i = a;
        src2_i = b;
    endtask

    vec_t        vecs[$];
    logic [31:0] pc_hold;
    logic [31:0] addi_m1;

    initial begin
        addi_m1 = 32'hfff0_0093;
        rst_i   = 1'b1;
        drive(addi_m1, 32'h0, 32'h0);
        tick();
        tick();
        chk("reset_pc",   pc_o,         RST_PC);
        chk("reset_halt", 32'(halt_o),  32'd0);
        chk("reset_wen",  32'(wen_o),   32'd0);

        rst_i  = 1'b0;
        m_pc   = RST_PC;
        m_halt = 1'b0;
        chk_en = 1'b1;

        // ADDI x1,x0,-1
        drive(addi_m1, 32'h0, 32'h0);
        #1;
        chk("addi_wen",   32'(wen_o), 32'd1);
        chk("addi_rd",    32'(rd_o),  32'd1);
        chk("addi_wdata", wdata_o,    32'hffff_ffff);
        tick();
        chk("addi_npc", pc_o, 32'h8000_0004);

        // BLT x1,x2,+8 with -1 < 1 signed
        drive(32'h0020_c463, 32'hffff_ffff, 32'h0000_0001);
        #1;
        chk("blt_wen", 32'(wen_o), 32'd0);
        tick();
        chk("blt_npc", pc_o, 32'h8000_000c);

        // BLTU same operands: not taken
        drive(32'h0020_e463, 32'hffff_ffff, 32'h0000_0001);
        tick();
        chk("bltu_npc", pc_o, 32'h8000_0010);

        // JALR x1,0(x5)
        drive(32'h0002_80e7, 32'h8000_0103, 32'h0);
        #1;
        chk("jalr_wdata", wdata_o, 32'h8000_0014);
        tick();
        chk("jalr_npc", pc_o, 32'h8000_0102);

        // ADDI x0,x0,5 never writes
        drive(32'h0050_0013, 32'h0, 32'h0);
        #1;
        chk("x0_wen", 32'(wen_o), 32'd0);
        tick();

        // LW is unsupported
        drive(32'h0000_2083, 32'h0, 32'h0);
        #1;
        chk("load_illegal", 32'(illegal_o), 32'd1);
        tick();
        chk("load_npc", pc_o, 32'h8000_010a);

        // MULHU x3,x1,x2
        drive(32'h0220_b1b3, 32'hffff_ffff, 32'h0000_0002);
        #1;
`ifdef FDE_MUL_EN
        chk("mulhu_wdata", wdata_o, 32'h0000_0001);
        chk("mulhu_wen",   32'(wen_o), 32'd1);
`else
        chk("mulhu_illegal", 32'(illegal_o), 32'd1);
`endif
        tick();

        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h7fff_ffff, 32'h1});
        vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h0, 32'h1});
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3, OP), 32'h1, 32'h23});
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3, OP), 32'hffff_ffff, 32'h0});
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3, OP), 32'hffff_ffff, 32'h0});
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3, OP), 32'ha5a5_a5a5, 32'hffff_0000});
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3, OP), 32'h8000_0000, 32'h4});
        vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3, OP), 32'h8000_0000, 32'h4});
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3, OP), 32'h0f0f_0000, 32'h00f0_f00f});
        vecs.push_back('{enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3, OP), 32'h0f0f_1234, 32'hff00_ff00});
        vecs.push_back('{enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd3, OP), 32'h1, 32'h1});
        vecs.push_back('{enc_i({7'h20, 5'd8}, 5'd1, 3'd5, 5'd3, OPI), 32'hf000_0000, 32'h0});
        vecs.push_back('{enc_i({7'h00, 5'd31}, 5'd1, 3'd1, 5'd3, OPI), 32'h1, 32'h0});
        vecs.push_back('{enc_i({7'h10, 5'd1}, 5'd1, 3'd1, 5'd3, OPI), 32'h1, 32'h0});
        vecs.push_back('{enc_i({7'h01, 5'd1}, 5'd1, 3'd5, 5'd3, OPI), 32'h1, 32'h0});
        vecs.push_back('{enc_i(12'h800, 5'd1, 3'd0, 5'd3, OPI), 32'h0, 32'h0});
        vecs.push_back('{enc_i(12'hfff, 5'd1, 3'd2, 5'd3, OPI), 32'h5, 32'h0});
        vecs.push_back('{enc_i(12'hfff, 5'd1, 3'd3, 5'd3, OPI), 32'h5, 32'h0});
        vecs.push_back('{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h3, 32'hffff_fffe});
        vecs.push_back('{enc_r(7'h01, 5'd2, 5'd1, 3'd1, 5'd3, OP), 32'hffff_ffff, 32'hffff_ffff});
        vecs.push_back('{enc_r(7'h01, 5'd2, 5'd1, 3'd2, 5'd3, OP), 32'hffff_ffff, 32'h2});
        vecs.push_back('{enc_r(7'h01, 5'd2, 5'd1, 3'd4, 5'd3, OP), 32'h7, 32'h2});
        vecs.push_back('{{20'habcde, 5'd4, LUI}, 32'h0, 32'h0});
        vecs.push_back('{{20'hfffff, 5'd5, AUIPC}, 32'h0, 32'h0});
        vecs.push_back('{enc_j(21'h1f_fff0, 5'd1), 32'h0, 32'h0});
        vecs.push_back('{enc_b(13'h1ffc, 5'd2, 5'd1, 3'd0), 32'h5, 32'h5});
        vecs.push_back('{enc_b(13'd8, 5'd2, 5'd1, 3'd1), 32'h5, 32'h5});
        vecs.push_back('{enc_b(13'd12, 5'd2, 5'd1, 3'd5), 32'h1, 32'hffff_ffff});
        vecs.push_back('{enc_b(13'd12, 5'd2, 5'd1, 3'd7), 32'h1, 32'hffff_ffff});
        vecs.push_back('{enc_b(13'd16, 5'd2, 5'd1, 3'd2), 32'h1, 32'h1});
        vecs.push_back('{enc_i(12'h0, 5'd1, 3'd1, 5'd1, JALR), 32'h100, 32'h0});
        vecs.push_back('{32'h0000_0073, 32'h0, 32'h0});
        vecs.push_back('{32'h0000_000b, 32'h0, 32'h0});
        foreach (vecs[i]) begin
            drive(vecs[i].ins, vecs[i].a, vecs[i].b);
            tick();
        end

        // EBREAK freezes the core until reset
        drive(32'h0010_0073, 32'h0, 32'h0);
        #1;
        pc_hold = m_pc;
        chk("ebreak_wen",     32'(wen_o),  32'd0);
        chk("ebreak_prehalt", 32'(halt_o), 32'd0);
        tick();
        drive(addi_m1, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("halted_flag", 32'(halt_o), 32'd1);
            chk("halted_pc",   pc_o,        pc_hold);
            chk("halted_wen",  32'(wen_o),  32'd0);
            tick();
        end

        // Asynchronous reset mid-cycle
        chk_en = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        chk("midrst_pc",   pc_o,        RST_PC);
        chk("midrst_halt", 32'(halt_o), 32'd0);
        chk("midrst_wen",  32'(wen_o),  32'd0);
        tick();
        rst_i  = 1'b0;
        m_pc   = RST_PC;
        m_halt = 1'b0;
        chk_en = 1'b1;
        drive(addi_m1, 32'h0, 32'h0);
        tick();
        chk("postrst_npc", pc_o, 32'h8000_0004);
        drive(enc_i(12'h7ff, 5'd1, 3'd0, 5'd2, OPI), 32'hffff_ffff, 32'h0);
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
